// File: rtl/usart_pkg.sv
// Shared types for the USART transmitter: parity modes, FSM states and a
// frame-length helper usable in localparam expressions.
package usart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/usart_tx_frame_if.sv
// Word handshake between the bus-side producer and the USART transmitter.
interface usart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  // Valid/ready: a word transfers on a rising clock edge where tx_valid and
  // tx_ready are both high; tx_ready never depends on tx_valid, and tx_data
  // only has to be stable in the transfer cycle.
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/usart_tx_fifo.sv
// Synchronous circular FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter.
module usart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usart_tx_frame.sv
// Parametrised USART transmitter with internal bit timing. Defining
// USART_TX_FIFO_EN buffers words in a FIFO; otherwise a single holding register.
module usart_tx_frame
  import usart_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int CLOCKS_PER_BIT = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  usart_tx_frame_if.slave             tx,
  output logic                        tx_pin,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output tx_state_t                   fsm_state
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam parity_t        PAR_MODE   = parity_t'(2'(PARITY));
  localparam logic           HAS_PARITY = (PAR_MODE != PARITY_NONE);
  localparam logic           ODD_PARITY = (PAR_MODE == PARITY_ODD);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0]  BIT_LAST   = BW'(DATA_BITS - 1);

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] head;

  tx_state_t            state;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 bit_end;
  logic                 stop_last;

  assign tx.tx_ready = !full;
  assign push        = tx.tx_valid && !full;

`ifdef USART_TX_FIFO_EN
  usart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (tx.tx_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );
`else
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  // Push needs an empty register and pop needs a full one, so they never coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= tx.tx_data;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign full       = hold_valid;
  assign empty      = !hold_valid;
  assign head       = hold_data;
  assign fifo_level = {{(LW-1){1'b0}}, hold_valid};
`endif

  assign bit_end   = (timer == TIMER_LAST);
  assign stop_last = (STOP_BITS == 1) || stop_cnt;

  // Words leave the buffer from IDLE, or at the end of the last stop bit so
  // back-to-back frames run without an idle gap.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if (state == STOP && bit_end && stop_last) begin
        pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx_pin   <= 1'b1;
    end else begin
      if (state == IDLE || bit_end) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      case (state)
        IDLE: begin
          tx_pin <= 1'b1;
          if (pop) begin
            shift   <= head;
            par_bit <= (^head) ^ ODD_PARITY;
            state   <= START;
            tx_pin  <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx_pin  <= shift[0];
            bit_cnt <= '0;
          end
        end

        // tx_pin is loaded with the next bit as the current one ends.
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              if (HAS_PARITY) begin
                state  <= usart_pkg::PARITY;
                tx_pin <= par_bit;
              end else begin
                state    <= STOP;
                tx_pin   <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              tx_pin  <= shift[1];
            end
          end
        end

        usart_pkg::PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            tx_pin   <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (stop_last) begin
              if (pop) begin
                shift   <= head;
                par_bit <= (^head) ^ ODD_PARITY;
                state   <= START;
                tx_pin  <= 1'b0;
              end else begin
                state  <= IDLE;
                tx_pin <= 1'b1;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        default: begin
          state  <= IDLE;
          tx_pin <= 1'b1;
        end
      endcase
    end
  end

  assign tx_busy   = (state != IDLE) || (fifo_level != '0);
  assign fsm_state = state;

endmodule

// File: tb/tb_usart_tx_frame.sv
// Directed bench for usart_tx_frame: five parameter configurations sharing one
// clock and reset, checked bit-by-bit at every falling edge.
module tb_usart_tx_frame;
  import usart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

`ifdef USART_TX_FIFO_EN
  localparam int   EXP_PEAK = 3;
  localparam logic EXP_DROP = 1'b0;
`else
  localparam int   EXP_PEAK = 1;
  localparam logic EXP_DROP = 1'b1;
`endif

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2, 4: 5N1; all 4 clocks per bit
  usart_tx_frame_if #(.DATA_BITS(8)) if_n1 ();
  usart_tx_frame_if #(.DATA_BITS(8)) if_e1 ();
  usart_tx_frame_if #(.DATA_BITS(8)) if_o1 ();
  usart_tx_frame_if #(.DATA_BITS(8)) if_n2 ();
  usart_tx_frame_if #(.DATA_BITS(5)) if_d5 ();

  logic      pin_v  [5];
  logic      busy_v [5];
  logic [2:0] lvl_v [5];
  tx_state_t st_v   [5];

  usart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLOCKS_PER_BIT(4), .FIFO_DEPTH(4)) u_n1 (
    .clock(clock), .reset(reset), .tx(if_n1), .tx_pin(pin_v[0]), .tx_busy(busy_v[0]),
    .fifo_level(lvl_v[0]), .fsm_state(st_v[0]));
  usart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLOCKS_PER_BIT(4), .FIFO_DEPTH(4)) u_e1 (
    .clock(clock), .reset(reset), .tx(if_e1), .tx_pin(pin_v[1]), .tx_busy(busy_v[1]),
    .fifo_level(lvl_v[1]), .fsm_state(st_v[1]));
  usart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLOCKS_PER_BIT(4), .FIFO_DEPTH(4)) u_o1 (
    .clock(clock), .reset(reset), .tx(if_o1), .tx_pin(pin_v[2]), .tx_busy(busy_v[2]),
    .fifo_level(lvl_v[2]), .fsm_state(st_v[2]));
  usart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .CLOCKS_PER_BIT(4), .FIFO_DEPTH(4)) u_n2 (
    .clock(clock), .reset(reset), .tx(if_n2), .tx_pin(pin_v[3]), .tx_busy(busy_v[3]),
    .fifo_level(lvl_v[3]), .fsm_state(st_v[3]));
  usart_tx_frame #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .CLOCKS_PER_BIT(4), .FIFO_DEPTH(4)) u_d5 (
    .clock(clock), .reset(reset), .tx(if_d5), .tx_pin(pin_v[4]), .tx_busy(busy_v[4]),
    .fifo_level(lvl_v[4]), .fsm_state(st_v[4]));

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         acc_cnt = 0;
  int         rx_cnt  = 0;
  logic       mon_en  = 1'b0;
  int         peak    = 0;
  logic       rdy_drop = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (int'(lvl_v[0]) > peak) peak = int'(lvl_v[0]);
      if (!if_n1.tx_ready) rdy_drop = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic ready_of(input int s);
    case (s)
      0:       return if_n1.tx_ready;
      1:       return if_e1.tx_ready;
      2:       return if_o1.tx_ready;
      3:       return if_n2.tx_ready;
      default: return if_d5.tx_ready;
    endcase
  endfunction

  task automatic drive(input int s, input logic v, input logic [7:0] d);
    case (s)
      0:       begin if_n1.tx_valid = v; if_n1.tx_data = d;      end
      1:       begin if_e1.tx_valid = v; if_e1.tx_data = d;      end
      2:       begin if_o1.tx_valid = v; if_o1.tx_data = d;      end
      3:       begin if_n2.tx_valid = v; if_n2.tx_data = d;      end
      default: begin if_d5.tx_valid = v; if_d5.tx_data = d[4:0]; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic push(input int s, input logic [7:0] d);
    int w = 0;
    drive(s, 1'b1, d);
    while (!ready_of(s) && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("push_wait", (w < 200), 1);
    @(negedge clock);
    drive(s, 1'b0, d);
  endtask

  // bits[0] is the first bit on the line; each bit must hold exactly 4 samples.
  task automatic check_bits(input int s, input string tag, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        check(tag, pin_v[s], bits[i]);
        if (i == 0 && c == 0) check({tag, "_busy"}, busy_v[s], 1);
      end
    end
  endtask

  task automatic send_frame(input int s, input string tag, input logic [7:0] d,
                            input logic [15:0] bits, input int nbits);
    push(s, d);
    check({tag, "_lvl"}, lvl_v[s], 1);
    check({tag, "_pre"}, pin_v[s], 1);
    check_bits(s, tag, bits, nbits);
    @(negedge clock);
    check({tag, "_busy_end"}, busy_v[s], 0);
    check({tag, "_pin_end"}, pin_v[s], 1);
    check({tag, "_st_end"}, st_v[s], IDLE);
  endtask

  // Mid-bit sampling receiver on the 8N1 line.
  task automatic rx_frame(output logic [7:0] d);
    int w = 0;
    d = '0;
    while (pin_v[0] !== 1'b0 && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("rx_start_wait", (w < 200), 1);
    repeat (2) @(negedge clock);
    check("rx_start", pin_v[0], 0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clock);
      d[i] = pin_v[0];
    end
    repeat (4) @(negedge clock);
    check("rx_stop", pin_v[0], 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int s = 0; s < 5; s++) drive(s, 1'b0, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    for (int s = 0; s < 5; s++) begin
      check("rst_pin", pin_v[s], 1);
      check("rst_ready", ready_of(s), 1);
      check("rst_busy", busy_v[s], 0);
      check("rst_lvl", lvl_v[s], 0);
      check("rst_state", st_v[s], IDLE);
    end
    reset = 1'b0;
    @(negedge clock);

    send_frame(0, "n1_aa", 8'hAA, 16'b1101010100,   frame_bits(8, 0, 1));
    send_frame(1, "e1_07", 8'h07, 16'b11000001110,  frame_bits(8, 1, 1));
    send_frame(2, "o1_07", 8'h07, 16'b10000001110,  frame_bits(8, 2, 1));
    send_frame(3, "n2_aa", 8'hAA, 16'b11101010100,  frame_bits(8, 0, 2));
    send_frame(4, "d5_1b", 8'h1B, 16'b1110110,      frame_bits(5, 0, 1));

    // four words back-to-back: contiguous frames
    peak = 0; rdy_drop = 1'b0; mon_en = 1'b1;
    fork
      begin
        push(0, 8'h55);
        push(0, 8'h0F);
        push(0, 8'hF0);
        push(0, 8'h3C);
      end
      begin
        @(negedge clock);
        check_bits(0, "b2b_55", 16'b1010101010, 10);
        check_bits(0, "b2b_0f", 16'b1000011110, 10);
        check_bits(0, "b2b_f0", 16'b1111100000, 10);
        check_bits(0, "b2b_3c", 16'b1001111000, 10);
      end
    join
    mon_en = 1'b0;
    check("b2b_peak", peak, EXP_PEAK);
    check("b2b_rdy_drop", rdy_drop, EXP_DROP);
    @(negedge clock);
    check("b2b_busy_end", busy_v[0], 0);

    // hold tx_valid into a full buffer: nothing lost or duplicated
    rdy_drop = 1'b0; mon_en = 1'b1;
    fork
      begin
        logic [7:0] words [6];
        words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        for (int k = 0; k < 6; k++) begin
          push(0, words[k]);
          exp_q.push_back(words[k]);
          acc_cnt++;
        end
      end
      begin
        logic [7:0] got;
        for (int k = 0; k < 6; k++) begin
          rx_frame(got);
          rx_cnt++;
          if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
          else check("sb_data", got, exp_q.pop_front());
        end
      end
    join
    mon_en = 1'b0;
    check("full_rdy_drop", rdy_drop, 1);
    check("full_count", rx_cnt, acc_cnt);
    check("full_q_empty", exp_q.size(), 0);
    begin
      int w = 0;
      while (busy_v[0] && w < 20) begin
        @(negedge clock);
        w++;
      end
      check("full_busy_wait", (w < 20), 1);
    end
    check("full_lvl_end", lvl_v[0], 0);

    // reset in the middle of a data bit with a word still buffered
    @(negedge clock);
    push(0, 8'hAA);
    push(0, 8'h0F);
    repeat (8) @(negedge clock);
    check("mid_state", st_v[0], DATA);
    check("mid_lvl", lvl_v[0], 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mrst_pin", pin_v[0], 1);
    check("mrst_lvl", lvl_v[0], 0);
    check("mrst_ready", ready_of(0), 1);
    check("mrst_busy", busy_v[0], 0);
    check("mrst_state", st_v[0], IDLE);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("mrst_quiet", pin_v[0], 1);
    end
    send_frame(0, "post_81", 8'h81, 16'b1100000010, frame_bits(8, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
